// File: rtl/pipe_if_id_stage_if.sv
// ----------------------------------------------------------------------------
// pipe_if_id_stage_if
// ----------------------------------------------------------------------------
// Handshake and data bundle between fetch, the IF/ID stage and decode.
//
//   Fetch side :  in_valid, in_ready, instruction, pc_plus4
//   Decode side:  out_valid, out_ready, instruction_out, pc_plus4_out
//
// Modports:
//   slave  - the IF/ID stage itself (consumes fetch data, produces decode data)
//   master - the surrounding environment (drives fetch data and out_ready)
// ----------------------------------------------------------------------------
interface pipe_if_id_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc_plus4;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instruction_out;
    logic [PC_W-1:0]    pc_plus4_out;

    modport slave (
        input  in_valid,
        input  instruction,
        input  pc_plus4,
        input  out_ready,
        output in_ready,
        output out_valid,
        output instruction_out,
        output pc_plus4_out
    );

    modport master (
        output in_valid,
        output instruction,
        output pc_plus4,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  instruction_out,
        input  pc_plus4_out
    );
endinterface

// File: rtl/pipe_if_id_stage.sv
// ----------------------------------------------------------------------------
// pipe_if_id_stage
// ----------------------------------------------------------------------------
// IF/ID pipeline register of the pipelined MIPS core. Carries the fetched
// instruction and its PC+4 from fetch to decode with a valid/ready handshake.
// A main entry drives decode; a skid entry catches one extra instruction
// when decode stalls, so fetch can run at full rate and in_ready can be a
// pure function of registered state.
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   CLR_N    - asynchronous active-low reset
//   EN       - stage enable; 0 freezes all state and blocks both handshakes
//   FLUSH    - synchronous squash of every held entry (branch/jump)
//   bus      - pipe_if_id_stage_if.slave: fetch-side and decode-side
//              handshake plus data
//   stall_cnt, skid_hit - only with PIPE_IF_ID_STALL_CNT_EN defined
//
// Optional feature (macro PIPE_IF_ID_STALL_CNT_EN):
//   stall_cnt - saturating 16-bit count of cycles where decode holds off a
//               valid main entry (EN=1, main valid, out_ready=0); cleared by
//               reset and FLUSH
//   skid_hit  - high during the cycle an input is captured into the skid
//               entry (ONE -> TWO transition)
// ----------------------------------------------------------------------------
module pipe_if_id_stage #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              EN,
    input  logic              FLUSH,
    pipe_if_id_stage_if.slave bus
`ifdef PIPE_IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic              skid_hit
`endif
);

    // Occupancy encoding: bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [INSTR_W-1:0] m_instr_reg, m_instr_next;
    logic [PC_W-1:0]    m_pc_reg, m_pc_next;
    logic [INSTR_W-1:0] s_instr_reg, s_instr_next;
    logic [PC_W-1:0]    s_pc_reg, s_pc_next;

    logic m_v;
    logic s_v;
    logic push;
    logic pop;

    assign m_v = (state_reg != ST_EMPTY);
    assign s_v = (state_reg == ST_TWO);

    // CLR_N is folded in so in_ready is low for the whole reset window.
    assign bus.in_ready        = EN & ~s_v & CLR_N;
    assign bus.out_valid       = EN & m_v;
    assign bus.instruction_out = m_v ? m_instr_reg : NOP_INSTR;
    assign bus.pc_plus4_out    = m_v ? m_pc_reg : '0;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_reg   <= ST_EMPTY;
            m_instr_reg <= '0;
            m_pc_reg    <= '0;
            s_instr_reg <= '0;
            s_pc_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            m_instr_reg <= m_instr_next;
            m_pc_reg    <= m_pc_next;
            s_instr_reg <= s_instr_next;
            s_pc_reg    <= s_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and data steering. With EN=0 both push and pop are
    // forced low by the output equations, so every branch below holds.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        m_instr_next = m_instr_reg;
        m_pc_next    = m_pc_reg;
        s_instr_next = s_instr_reg;
        s_pc_next    = s_pc_reg;

        if (FLUSH) begin
            // Squash wins over any push; data contents are left as-is since
            // the valid flags already mark them dead.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (push) begin
                        state_next   = ST_ONE;
                        m_instr_next = bus.instruction;
                        m_pc_next    = bus.pc_plus4;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        m_instr_next = bus.instruction;
                        m_pc_next    = bus.pc_plus4;
                    end else if (push) begin
                        state_next   = ST_TWO;
                        s_instr_next = bus.instruction;
                        s_pc_next    = bus.pc_plus4;
                    end else if (pop) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Skid is older than anything fetch can offer, so it
                    // moves into main; in_ready is low so no push here.
                    if (pop) begin
                        state_next   = ST_ONE;
                        m_instr_next = s_instr_reg;
                        m_pc_next    = s_pc_reg;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_IF_ID_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Decode stall statistics
    // ------------------------------------------------------------------
    logic [15:0] stall_cnt_reg;
    logic        stall_cycle;

    assign stall_cycle = EN & m_v & ~bus.out_ready;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            stall_cnt_reg <= '0;
        end else if (FLUSH) begin
            stall_cnt_reg <= '0;
        end else if (stall_cycle && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign skid_hit  = (state_reg == ST_ONE) & push & ~pop & ~FLUSH;
`endif

endmodule

// File: tb/tb_pipe_if_id_stage.sv
// ----------------------------------------------------------------------------
// tb_pipe_if_id_stage
// ----------------------------------------------------------------------------
// Bench for the IF/ID stage. The reference model is a depth-2 FIFO held in
// queues: in_ready means "fewer than two held", out_valid means "at least
// one held", the decode side shows the queue head, FLUSH/reset empty it.
// Directed scenarios cover reset, streaming, back-pressure, flush and
// enable freeze; a randomized run compares every cycle against the model.
// ----------------------------------------------------------------------------
module tb_pipe_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] A_I = 32'h2008_0005;
    localparam logic [31:0] A_P = 32'h0000_0004;
    localparam logic [31:0] B_I = 32'h2009_000A;
    localparam logic [31:0] B_P = 32'h0000_0008;
    localparam logic [31:0] C_I = 32'h1234_5678;
    localparam logic [31:0] C_P = 32'h0000_000C;

    logic CLK;
    logic CLR_N;
    logic EN;
    logic FLUSH;

    pipe_if_id_stage_if #(.INSTR_W(32), .PC_W(32)) bus ();

`ifdef PIPE_IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic        skid_hit;
    int unsigned stall_model;
`endif

    pipe_if_id_stage #(
        .INSTR_W  (32),
        .PC_W     (32),
        .NOP_INSTR(NOP)
    ) dut (
        .CLK      (CLK),
        .CLR_N    (CLR_N),
        .EN       (EN),
        .FLUSH    (FLUSH),
        .bus      (bus.slave)
`ifdef PIPE_IF_ID_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .skid_hit (skid_hit)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_clear();
        q_instr.delete();
        q_pc.delete();
`ifdef PIPE_IF_ID_STALL_CNT_EN
        stall_model = 0;
`endif
    endtask

    // Apply one cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic en, input logic fl);
        bus.in_valid    = v;
        bus.instruction = ins;
        bus.pc_plus4    = pc;
        bus.out_ready   = ordy;
        EN              = en;
        FLUSH           = fl;
        #1;
    endtask

    // Advance one clock and update the FIFO model from the current inputs.
    task automatic tick();
        logic        do_push, do_pop;
        logic [31:0] pi, pp;
        do_push = bus.in_valid && EN && CLR_N && (q_instr.size() < 2);
        do_pop  = EN && CLR_N && (q_instr.size() > 0) && bus.out_ready;
        pi = bus.instruction;
        pp = bus.pc_plus4;
`ifdef PIPE_IF_ID_STALL_CNT_EN
        if (!CLR_N || FLUSH)
            stall_model = 0;
        else if (EN && q_instr.size() > 0 && !bus.out_ready && stall_model < 32'hFFFF)
            stall_model++;
`endif
        @(posedge CLK);
        if (!CLR_N || FLUSH) begin
            if (do_pop && CLR_N)
                $display("[%0t] pop  %h / %h (flush cycle)", $time, q_instr[0], q_pc[0]);
            q_instr.delete();
            q_pc.delete();
        end else begin
            if (do_pop) begin
                $display("[%0t] pop  %h / %h", $time, q_instr[0], q_pc[0]);
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (do_push) begin
                $display("[%0t] push %h / %h", $time, pi, pp);
                q_instr.push_back(pi);
                q_pc.push_back(pp);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        CLR_N = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
                $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++;
                $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
            n_cmp++; if (bus.instruction_out !== NOP) begin n_err++;
                $display("FAIL reset_instr got=%h exp=%h", bus.instruction_out, NOP); end
            n_cmp++; if (bus.pc_plus4_out !== 32'h0) begin n_err++;
                $display("FAIL reset_pc got=%h exp=0", bus.pc_plus4_out); end
            tick();
        end
        CLR_N = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL release_cycle1 got rdy=%b vld=%b exp rdy=1 vld=0",
                     bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_streaming();
        drive(1'b1, A_I, A_P, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL stream_c0 got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); end
        tick();
        drive(1'b1, B_I, B_P, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.instruction_out !== A_I ||
                     bus.pc_plus4_out !== A_P || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL stream_a got vld=%b %h/%h rdy=%b exp vld=1 %h/%h rdy=1",
                     bus.out_valid, bus.instruction_out, bus.pc_plus4_out, bus.in_ready, A_I, A_P); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.instruction_out !== B_I ||
                     bus.pc_plus4_out !== B_P || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL stream_b got vld=%b %h/%h rdy=%b exp vld=1 %h/%h rdy=1",
                     bus.out_valid, bus.instruction_out, bus.pc_plus4_out, bus.in_ready, B_I, B_P); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.instruction_out !== NOP) begin n_err++;
            $display("FAIL stream_drain got vld=%b %h exp vld=0 %h", bus.out_valid, bus.instruction_out, NOP); end
    endtask

    task automatic test_back_pressure();
        drive(1'b1, A_I, A_P, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, B_I, B_P, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.instruction_out !== A_I) begin n_err++;
            $display("FAIL bp_one got rdy=%b %h exp rdy=1 %h", bus.in_ready, bus.instruction_out, A_I); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.instruction_out !== A_I) begin n_err++;
            $display("FAIL bp_two got rdy=%b vld=%b %h exp rdy=0 vld=1 %h",
                     bus.in_ready, bus.out_valid, bus.instruction_out, A_I); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.instruction_out !== A_I || bus.in_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_pop_a got vld=%b %h rdy=%b exp vld=1 %h rdy=0",
                     bus.out_valid, bus.instruction_out, bus.in_ready, A_I); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.instruction_out !== B_I ||
                     bus.pc_plus4_out !== B_P || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_pop_b got vld=%b %h/%h rdy=%b exp vld=1 %h/%h rdy=1",
                     bus.out_valid, bus.instruction_out, bus.pc_plus4_out, bus.in_ready, B_I, B_P); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_empty got vld=%b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        // Flush from TWO with C offered while in_ready is low.
        drive(1'b1, A_I, A_P, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, B_I, B_P, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, C_I, C_P, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.instruction_out !== NOP ||
                     bus.pc_plus4_out !== 32'h0 || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_two got vld=%b %h/%h rdy=%b exp vld=0 %h/0 rdy=1",
                     bus.out_valid, bus.instruction_out, bus.pc_plus4_out, bus.in_ready, NOP); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL flush_no_c got vld=%b %h exp vld=0", bus.out_valid, bus.instruction_out); end
        // Flush from ONE with C offered while in_ready is high: still dropped.
        drive(1'b1, A_I, A_P, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, C_I, C_P, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_one_rdy got=%b exp=1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.instruction_out !== NOP) begin n_err++;
            $display("FAIL flush_one got vld=%b %h exp vld=0 %h", bus.out_valid, bus.instruction_out, NOP); end
        tick();
    endtask

    task automatic test_enable_freeze();
        drive(1'b1, A_I, A_P, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, C_I, C_P, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.instruction_out !== A_I) begin n_err++;
                $display("FAIL freeze_%0d got vld=%b rdy=%b %h exp vld=0 rdy=0 %h",
                         i, bus.out_valid, bus.in_ready, bus.instruction_out, A_I); end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.instruction_out !== A_I || bus.pc_plus4_out !== A_P) begin n_err++;
            $display("FAIL freeze_resume got vld=%b %h/%h exp vld=1 %h/%h",
                     bus.out_valid, bus.instruction_out, bus.pc_plus4_out, A_I, A_P); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL freeze_drain got vld=%b exp 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic        exp_rdy, exp_vld;
        logic [31:0] exp_i, exp_p;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 149) == 0) begin
                CLR_N = 1'b0;
                model_clear();
            end else begin
                CLR_N = 1'b1;
            end
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 24) == 0));
            exp_rdy = EN && CLR_N && (q_instr.size() < 2);
            exp_vld = EN && (q_instr.size() > 0);
            exp_i   = (q_instr.size() > 0) ? q_instr[0] : NOP;
            exp_p   = (q_pc.size() > 0) ? q_pc[0] : 32'h0;
            n_cmp++; if (bus.in_ready !== exp_rdy || bus.out_valid !== exp_vld ||
                         bus.instruction_out !== exp_i || bus.pc_plus4_out !== exp_p) begin n_err++;
                $display("FAIL rand_%0d got rdy=%b vld=%b %h/%h exp rdy=%b vld=%b %h/%h", cyc,
                         bus.in_ready, bus.out_valid, bus.instruction_out, bus.pc_plus4_out,
                         exp_rdy, exp_vld, exp_i, exp_p); end
`ifdef PIPE_IF_ID_STALL_CNT_EN
            n_cmp++; if (stall_cnt !== 16'(stall_model) ||
                         skid_hit !== (CLR_N && !FLUSH && EN && q_instr.size() == 1 &&
                                       bus.in_valid && !bus.out_ready)) begin n_err++;
                $display("FAIL rand_stat_%0d got cnt=%0d hit=%b exp cnt=%0d", cyc,
                         stall_cnt, skid_hit, stall_model); end
`endif
            tick();
        end
    endtask

    initial begin
        CLR_N           = 1'b0;
        EN              = 1'b1;
        FLUSH           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        bus.pc_plus4    = '0;
        bus.out_ready   = 1'b0;
        model_clear();
        @(posedge CLK);
        #1;
        test_reset();
        tick();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_enable_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_if_id_stage.md
Name: pipe_if_id_stage

Overview:
- Parametrised IF/ID pipeline stage of the pipelined MIPS core, sitting between fetch and decode.
- Carries the instruction word plus its PC+4 through a valid/ready handshake.
- A 2-entry skid buffer lets fetch run at full rate while decode back-pressures.
- Supports global enable (EN), synchronous flush for branch/jump squash, and forces a NOP onto the decode side when the stage is empty.

Parameters:
- INSTR_W, 32, instruction word width.
- PC_W, 32, width of PC+4 carried alongside the instruction.
- NOP_INSTR, 32'h0000_0000, value driven on instruction_out when out_valid=0 (INSTR_W bits).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- CLR_N  input  1  reset, asynchronous, active-low.
- EN  input  1  stage enable; 0 freezes all state.
- FLUSH  input  1  synchronous squash of all held entries.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- instruction  input  INSTR_W  fetched instruction.
- pc_plus4  input  PC_W  PC+4 of the fetched instruction.
- out_valid  output  1  decode-side entry valid.
- out_ready  input  1  decode consumes this cycle.
- instruction_out  output  INSTR_W  instruction to decode.
- pc_plus4_out  output  PC_W  PC+4 to decode.

Behaviour:
- Storage: main entry (m_v, m_instr, m_pc) drives the outputs; skid entry (s_v, s_instr, s_pc) is filled only when main is stalled.
- Reset (CLR_N=0, asynchronous):
  - m_v=0, s_v=0, all data registers=0.
  - Outputs: out_valid=0, in_ready=0 while reset is asserted, instruction_out=NOP_INSTR, pc_plus4_out=0.
  - After release, in_ready=1 from the first cycle.
- Combinational outputs:
  - in_ready = EN & ~s_v & CLR_N.
  - out_valid = EN & m_v.
  - instruction_out = m_v ? m_instr : NOP_INSTR.
  - pc_plus4_out = m_v ? m_pc : 0.
- Handshake events: push = in_valid & in_ready; pop = out_valid & out_ready.
- States:
  - EMPTY (m_v=0, s_v=0)
  - ONE (m_v=1, s_v=0)
  - TWO (m_v=1, s_v=1)
- Transitions (EN=1, FLUSH=0):
  - EMPTY: push -> ONE; input is loaded into main. Latency 1 cycle from input to output.
  - ONE, push & pop -> ONE; main reloads from input (full throughput).
  - ONE, push & ~pop -> TWO; input captured into skid.
  - ONE, ~push & pop -> EMPTY.
  - ONE, neither -> hold.
  - TWO: push is impossible (in_ready=0). pop -> ONE with skid moved into main, s_v cleared. ~pop -> hold.
- Ordering: strict FIFO; the skid entry is always older than any new input.
- FLUSH=1, regardless of EN:
  - Next cycle m_v=0 and s_v=0; data registers need not be cleared.
  - An input offered in the flush cycle is dropped, even if in_ready=1.
  - A pop in the flush cycle still counts as a consumed transfer.
- EN=0 with FLUSH=0:
  - All registers hold.
  - in_ready=0 and out_valid=0, so no push or pop can occur.
  - Data outputs keep showing the held entry.
- Data and flag handling:
  - No arithmetic is performed; data passes through unmodified.
  - Widths are fixed by the parameters; there is no truncation.
- Reset asserted mid-transfer: it wins immediately, and any entries in flight are discarded.

Optional Feature:
- Macro: PIPE_IF_ID_STALL_CNT_EN.
- When defined, adds output stall_cnt [15:0].
  - Increments on every cycle with EN=1 & m_v=1 & ~out_ready.
  - Saturates at 16'hFFFF; does not wrap.
  - Cleared by CLR_N and by FLUSH.
  - Also adds output skid_hit, a 1-cycle pulse on each ONE->TWO transition.
- When undefined, neither port exists and there is no counter logic.
- Core behaviour is identical in both builds.

Test Plan:
- Reset: hold CLR_N=0 with random inputs -> out_valid=0, in_ready=0, instruction_out=32'h0; release -> in_ready=1 next cycle.
- Streaming: out_ready=1, push 0x20080005/pc 0x4, then 0x2009000A/pc 0x8 on consecutive cycles -> each appears on the outputs 1 cycle later; no bubbles; state never reaches TWO.
- Back-pressure: in state ONE holding A, drop out_ready and push B -> in_ready falls to 0; A stays on outputs. Raise out_ready -> A pops, then B pops next cycle, in order; in_ready returns to 1 after B moves to main.
- Flush: in TWO (A, B held), assert FLUSH with in_valid=1 offering C -> next cycle out_valid=0 and instruction_out=NOP_INSTR; C never appears.
- Enable freeze: in ONE holding A, set EN=0 for 3 cycles with out_ready=1 -> out_valid=0, A not consumed, in_ready=0. EN=1 -> A pops.
- With PIPE_IF_ID_STALL_CNT_EN: stall decode 5 cycles with main valid -> stall_cnt=5 and skid_hit pulses once when B is captured; FLUSH -> stall_cnt=0.
